uart_rx_core: RTL and testbench

UART_RX_CORE -- requirements
Module: uart_rx_core

---
 rtl/uart_rx_core_if.sv | 23 ++
 rtl/uart_rx_core.sv | 174 +++++++++++++++++
 tb/tb_uart_rx_core.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_core_if.sv
// Receive-side handshake bundle for uart_rx_core: received word, status flags and consumer ready.
// master = the receiver core, slave = the consumer of received words.
interface uart_rx_core_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 data_ready;
    logic                 framing_error;
    logic                 parity_error;
    logic                 overrun_error;
    logic                 busy;

    modport master (
        output data_out, data_valid, framing_error, parity_error, overrun_error, busy,
        input  data_ready
    );

    modport slave (
        input  data_out, data_valid, framing_error, parity_error, overrun_error, busy,
        output data_ready
    );
endinterface

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver with majority-vote bit decision and a held-word valid/ready output.
// Optional parity bit checking is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_core #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic              sys_clk,
    input  logic              reset_n,
    input  logic              sample_tick,
    input  logic              rx_in,
    uart_rx_core_if.master    rx_bus
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int M  = OVERSAMPLE / 2;

    if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 8 || OVERSAMPLE > 64 ||
        (OVERSAMPLE % 2) != 0 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
        $error("uart_rx_core: illegal parameter value");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t                 state_q, state_d;
    logic                   rx_sync_p0, rx_sync_p1;
    logic [CW-1:0]          cnt;
    logic [3:0]             bit_cnt;
    logic                   samp_a, samp_b;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   stop_err_q;
    logic [DATA_BITS-1:0]   data_q;
    logic                   valid_q, fe_q, ov_q;
    logic                   maj, in_frame, decide, last_data, complete, frame_fe;

    // rx_sync_p1 is the synchronized line (idle high)
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_sync_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
        end else begin
            rx_sync_p0 <= rx_in;
            rx_sync_p1 <= rx_sync_p0;
        end
    end

    assign maj       = (samp_a & samp_b) | (samp_a & rx_sync_p1) | (samp_b & rx_sync_p1);
    assign in_frame  = (state_q != S_IDLE) && (state_q != S_WAIT_HIGH);
    assign decide    = sample_tick && in_frame && (cnt == CW'(M + 1));
    assign last_data = (bit_cnt == 4'(DATA_BITS - 1));
    assign complete  = decide && (state_q == S_STOP) && (bit_cnt == 4'(STOP_BITS - 1));
    assign frame_fe  = stop_err_q | ~maj;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (sample_tick && !rx_sync_p1) state_d = S_START;
            S_START:     if (decide) state_d = maj ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
            S_DATA:      if (decide && last_data) state_d = S_PARITY;
            S_PARITY:    if (decide) state_d = S_STOP;
`else
            S_DATA:      if (decide && last_data) state_d = S_STOP;
`endif
            S_STOP:      if (complete) state_d = maj ? S_IDLE : S_WAIT_HIGH;
            S_WAIT_HIGH: if (sample_tick && rx_sync_p1) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rx_bus.busy = (state_q != S_IDLE);
    end

    // Bit timing, majority samples and frame assembly, all advanced by sample_tick only
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            bit_cnt    <= '0;
            samp_a     <= 1'b1;
            samp_b     <= 1'b1;
            shift_q    <= '0;
            stop_err_q <= 1'b0;
        end else if (sample_tick) begin
            if (!in_frame)                         cnt <= '0;
            else if (cnt == CW'(OVERSAMPLE - 1))   cnt <= '0;
            else                                   cnt <= cnt + 1'b1;

            if (cnt == CW'(M - 1)) samp_a <= rx_sync_p1;
            if (cnt == CW'(M))     samp_b <= rx_sync_p1;

            if (decide) begin
                case (state_q)
                    S_START: begin
                        bit_cnt    <= '0;
                        stop_err_q <= 1'b0;
                    end
                    S_DATA: begin
                        shift_q <= {maj, shift_q[DATA_BITS-1:1]};
                        bit_cnt <= last_data ? 4'd0 : bit_cnt + 4'd1;
                    end
                    S_STOP: begin
                        stop_err_q <= stop_err_q | ~maj;
                        bit_cnt    <= complete ? 4'd0 : bit_cnt + 4'd1;
                    end
                    default: bit_cnt <= '0;
                endcase
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit_q, pe_q, frame_pe;

    assign frame_pe = (^shift_q) ^ par_bit_q ^ (PARITY_ODD != 0);

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n)                            par_bit_q <= 1'b0;
        else if (decide && state_q == S_PARITY)  par_bit_q <= maj;
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n)                                  pe_q <= 1'b0;
        else if (complete && (!valid_q || rx_bus.data_ready)) pe_q <= frame_pe;
    end

    assign rx_bus.parity_error = pe_q;
`else
    assign rx_bus.parity_error = 1'b0;
`endif

    // Output word handshake; a completion with the word still held only records an overrun
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else if (complete) begin
            if (!valid_q || rx_bus.data_ready) begin
                data_q  <= shift_q;
                fe_q    <= frame_fe;
                valid_q <= 1'b1;
                ov_q    <= 1'b0;
            end else begin
                ov_q    <= 1'b1;
            end
        end else if (valid_q && rx_bus.data_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign rx_bus.data_out      = data_q;
    assign rx_bus.data_valid    = valid_q;
    assign rx_bus.framing_error = fe_q;
    assign rx_bus.overrun_error = ov_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at default parameters (8 data bits, 16x oversample, 1 stop bit),
// sample_tick on every second sys_clk; parity scenarios build only with UART_RX_PARITY_EN.
module tb_uart_rx_core;

    localparam int BIT_CLKS = 16 * 2;

    logic sys_clk = 1'b0;
    logic reset_n = 1'b0;
    logic sample_tick = 1'b0;
    logic rx_in = 1'b1;

    int checks = 0;
    int failures = 0;

    uart_rx_core_if #(.DATA_BITS(8)) rx_bus ();

    uart_rx_core #(
        .DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(1), .PARITY_ODD(0)
    ) dut (
        .sys_clk(sys_clk),
        .reset_n(reset_n),
        .sample_tick(sample_tick),
        .rx_in(rx_in),
        .rx_bus(rx_bus)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) sample_tick <= ~sample_tick;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        repeat (BIT_CLKS) @(negedge sys_clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par);
`else
        if (par === 1'bx) rx_in = 1'b1;
`endif
        send_bit(stop);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (rx_bus.data_valid !== 1'b1 && n < 4 * BIT_CLKS) begin
            @(negedge sys_clk);
            n++;
        end
        chk(tag, rx_bus.data_valid, 1);
    endtask

    task automatic ack(input string tag);
        @(negedge sys_clk);
        rx_bus.data_ready = 1'b1;
        @(posedge sys_clk);
        #1;
        rx_bus.data_ready = 1'b0;
        chk(tag, rx_bus.data_valid, 0);
        @(negedge sys_clk);
    endtask

    initial begin
        rx_bus.data_ready = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("rst_data_out", rx_bus.data_out, 0);
        chk("rst_valid", rx_bus.data_valid, 0);
        chk("rst_fe", rx_bus.framing_error, 0);
        chk("rst_ov", rx_bus.overrun_error, 0);
        chk("rst_busy", rx_bus.busy, 0);
        reset_n = 1'b1;
        repeat (BIT_CLKS) @(negedge sys_clk);

        // Clean 8N1 frame
        send_frame(8'hA5, 1'b0, 1'b1);
        wait_valid("a5_valid");
        chk("a5_data", rx_bus.data_out, 8'hA5);
        chk("a5_fe", rx_bus.framing_error, 0);
        chk("a5_pe", rx_bus.parity_error, 0);
        chk("a5_ov", rx_bus.overrun_error, 0);
        chk("a5_busy_idle", rx_bus.busy, 0);
        ack("a5_ack");
        chk("a5_hold", rx_bus.data_out, 8'hA5);
        ack("ready_no_valid");
        chk("ready_no_valid_data", rx_bus.data_out, 8'hA5);

        // Short low glitch is a false start
        rx_in = 1'b0;
        repeat (8) @(negedge sys_clk);
        chk("glitch_busy", rx_bus.busy, 1);
        rx_in = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge sys_clk);
        chk("glitch_valid", rx_bus.data_valid, 0);
        chk("glitch_busy_end", rx_bus.busy, 0);

        // Bad stop bit, then break for 3 bit periods: exactly one frame
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (3) send_bit(1'b0);
        repeat (2) send_bit(1'b1);
        wait_valid("3c_valid");
        chk("3c_data", rx_bus.data_out, 8'h3C);
        chk("3c_fe", rx_bus.framing_error, 1);
        chk("3c_single_frame", rx_bus.overrun_error, 0);
        ack("3c_ack");
        repeat (BIT_CLKS) @(negedge sys_clk);
        chk("3c_no_second", rx_bus.data_valid, 0);
        send_frame(8'h55, 1'b0, 1'b1);
        send_bit(1'b1);
        wait_valid("55_valid");
        chk("55_data", rx_bus.data_out, 8'h55);
        chk("55_fe", rx_bus.framing_error, 0);
        ack("55_ack");

        // Overrun: second frame while the first is still held
        send_frame(8'h11, 1'b0, 1'b1);
        send_bit(1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        send_bit(1'b1);
        chk("ov_valid", rx_bus.data_valid, 1);
        chk("ov_data", rx_bus.data_out, 8'h11);
        chk("ov_flag", rx_bus.overrun_error, 1);
        ack("ov_ack");
        chk("ov_data_kept", rx_bus.data_out, 8'h11);

        // Reset pulse during data bit 4
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rx_in = 1'b1;
        repeat (BIT_CLKS / 2) @(negedge sys_clk);
        chk("mid_busy", rx_bus.busy, 1);
        reset_n = 1'b0;
        #1;
        chk("mrst_data", rx_bus.data_out, 0);
        chk("mrst_valid", rx_bus.data_valid, 0);
        chk("mrst_fe", rx_bus.framing_error, 0);
        chk("mrst_pe", rx_bus.parity_error, 0);
        chk("mrst_ov", rx_bus.overrun_error, 0);
        chk("mrst_busy", rx_bus.busy, 0);
        repeat (3) @(negedge sys_clk);
        reset_n = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge sys_clk);
        chk("post_rst_busy", rx_bus.busy, 0);
        send_frame(8'h9E, 1'b1, 1'b1);
        send_bit(1'b1);
        wait_valid("9e_valid");
        chk("9e_data", rx_bus.data_out, 8'h9E);
        chk("9e_fe", rx_bus.framing_error, 0);
        chk("9e_ov", rx_bus.overrun_error, 0);
        ack("9e_ack");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b0, 1'b1);
        send_bit(1'b1);
        wait_valid("par0_valid");
        chk("par0_data", rx_bus.data_out, 8'h07);
        chk("par0_pe", rx_bus.parity_error, 1);
        ack("par0_ack");
        send_frame(8'h07, 1'b1, 1'b1);
        send_bit(1'b1);
        wait_valid("par1_valid");
        chk("par1_pe", rx_bus.parity_error, 0);
        ack("par1_ack");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
